aes_round_engine: RTL and testbench

AES_ROUND_ENGINE -- requirements
Module: aes_round_engine

---
 rtl/aes_round_engine.sv | 105 ++++++++++
 tb/tb_aes_round_engine.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/aes_round_engine.sv
// aes_round_engine: iterative AES-128 encryptor applying UNROLL rounds per clock
module aes_round_engine #(
  parameter int UNROLL  = 1,
  parameter int COUNT_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [127:0]       in_block,
  input  logic [1407:0]      round_keys,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [127:0]       out_block,
  output logic               busy,
  output logic [COUNT_W-1:0] blk_count
);
  if (!(UNROLL == 1 || UNROLL == 2 || UNROLL == 5 || UNROLL == 10)) begin : g_bad_unroll
    $error("aes_round_engine: UNROLL must be 1, 2, 5 or 10");
  end
  typedef enum logic [1:0] {IDLE, ROUND, DONE} phase_t;
  localparam logic [3:0] LAST_RND = 4'(11 - UNROLL);
  phase_t       phase;
  logic [127:0] state;
  logic [127:0] nxt;
  logic [3:0]   rnd;
  logic [3:0]   r;
  logic [127:0] rk [16];
  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    p = '0;
    for (int i = 0; i < 8; i++) begin
      p = p ^ (b[i] ? a : 8'h00);
      a = xt(a);
    end
    return p;
  endfunction
  // S-box as GF(2^8) inverse (x^254) followed by the affine map
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] v;
    v = x;
    for (int i = 0; i < 6; i++) v = gf_mul(gf_mul(v, v), x);
    v = gf_mul(v, v);
    return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
  endfunction
  function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] k, input logic last);
    logic [7:0]   b [16];
    logic [7:0]   m [16];
    logic [127:0] o;
    for (int i = 0; i < 16; i++) b[i] = sbox(s[127-8*((i%4)+4*((i/4+i%4)%4)) -: 8]);
    for (int c = 0; c < 4; c++) begin
      m[4*c]   = xt(b[4*c]) ^ xt(b[4*c+1]) ^ b[4*c+1] ^ b[4*c+2] ^ b[4*c+3];
      m[4*c+1] = b[4*c] ^ xt(b[4*c+1]) ^ xt(b[4*c+2]) ^ b[4*c+2] ^ b[4*c+3];
      m[4*c+2] = b[4*c] ^ b[4*c+1] ^ xt(b[4*c+2]) ^ xt(b[4*c+3]) ^ b[4*c+3];
      m[4*c+3] = xt(b[4*c]) ^ b[4*c] ^ b[4*c+1] ^ b[4*c+2] ^ xt(b[4*c+3]);
    end
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = (last ? b[i] : m[i]) ^ k[127-8*i -: 8];
    return o;
  endfunction
  // Chain UNROLL rounds starting at round rnd; round 10 skips MixColumns
  always_comb begin
    for (int i = 0; i < 16; i++) rk[i] = '0;
    for (int i = 0; i < 11; i++) rk[i] = round_keys[1407-128*i -: 128];
    nxt = state;
    r   = rnd;
    for (int j = 0; j < UNROLL; j++) begin
      r   = rnd + 4'(j);
      nxt = aes_round(nxt, rk[r], r == 4'd10);
    end
  end
  // Block FSM: accept in IDLE, iterate in ROUND, hold result in DONE until taken
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase     <= IDLE;
      state     <= '0;
      rnd       <= '0;
      blk_count <= '0;
    end else begin
      case (phase)
        IDLE: if (in_valid) begin
          state <= in_block ^ rk[0];
          rnd   <= 4'd1;
          phase <= ROUND;
        end
        ROUND: begin
          state <= nxt;
          rnd   <= rnd + 4'(UNROLL);
          phase <= (rnd == LAST_RND) ? DONE : ROUND;
        end
        DONE: if (out_ready) begin
          phase     <= IDLE;
          blk_count <= blk_count + COUNT_W'(1);
        end
        default: phase <= IDLE;
      endcase
    end
  end
  assign in_ready  = phase == IDLE;
  assign busy      = phase == ROUND;
  assign out_valid = phase == DONE;
  assign out_block = (phase == DONE) ? state : '0;
endmodule

// File: tb/tb_aes_round_engine.sv
// tb_aes_round_engine: directed FIPS-197 vectors, latency, backpressure, reset, streaming and wrap checks
module tb_aes_round_engine;
  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [3:0]       iv = '0;
  logic [3:0]       ordy = '0;
  logic [127:0]     in_block = '0;
  logic [1407:0]    round_keys = '0;
  wire  [3:0]       ir, ov, bz;
  wire  [3:0][127:0] ob;
  wire  [2:0][15:0] cnt;
  wire  [3:0]       cnt4;
  int               tests = 0;
  int               fails = 0;
  int               cyc = 0;
  int               cnt_exp [4] = '{0, 0, 0, 0};
  int               un [4] = '{1, 2, 5, 10};
  typedef struct {
    logic [127:0] key;
    logic [127:0] pt;
    logic [127:0] ct;
  } vec_t;
  vec_t vecs [3];
  logic [2047:0] sb_tab = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};
  aes_round_engine #(.UNROLL(1), .COUNT_W(16)) u1 (.clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]),
    .in_block(in_block), .round_keys(round_keys), .out_valid(ov[0]), .out_ready(ordy[0]), .out_block(ob[0]),
    .busy(bz[0]), .blk_count(cnt[0]));
  aes_round_engine #(.UNROLL(2), .COUNT_W(16)) u2 (.clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]),
    .in_block(in_block), .round_keys(round_keys), .out_valid(ov[1]), .out_ready(ordy[1]), .out_block(ob[1]),
    .busy(bz[1]), .blk_count(cnt[1]));
  aes_round_engine #(.UNROLL(5), .COUNT_W(16)) u5 (.clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ir[2]),
    .in_block(in_block), .round_keys(round_keys), .out_valid(ov[2]), .out_ready(ordy[2]), .out_block(ob[2]),
    .busy(bz[2]), .blk_count(cnt[2]));
  aes_round_engine #(.UNROLL(10), .COUNT_W(4)) u10 (.clk(clk), .rst_n(rst_n), .in_valid(iv[3]), .in_ready(ir[3]),
    .in_block(in_block), .round_keys(round_keys), .out_valid(ov[3]), .out_ready(ordy[3]), .out_block(ob[3]),
    .busy(bz[3]), .blk_count(cnt4));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  function automatic logic [7:0] sb(input logic [7:0] x);
    return sb_tab[2047-8*int'(x) -: 8];
  endfunction
  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction
  function automatic logic [1407:0] expand(input logic [127:0] key);
    logic [31:0]   w [44];
    logic [31:0]   t;
    logic [7:0]    rc;
    logic [1407:0] o;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {sb(t[23:16]), sb(t[15:8]), sb(t[7:0]), sb(t[31:24])} ^ {rc, 24'h0};
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int i = 0; i < 44; i++) o[1407-32*i -: 32] = w[i];
    return o;
  endfunction
  function automatic logic [127:0] model(input logic [127:0] pt, input logic [1407:0] rk);
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [7:0]   a0, a1, a2, a3;
    logic [127:0] o;
    for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ rk[1407-8*i -: 8];
    for (int rn = 1; rn <= 10; rn++) begin
      for (int i = 0; i < 16; i++) t[i] = sb(s[i]);
      for (int c = 0; c < 4; c++)
        for (int w = 0; w < 4; w++) s[w+4*c] = t[w+4*((c+w)%4)];
      if (rn < 10)
        for (int c = 0; c < 4; c++) begin
          a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
          s[4*c]   = xt(a0) ^ (xt(a1) ^ a1) ^ a2 ^ a3;
          s[4*c+1] = a0 ^ xt(a1) ^ (xt(a2) ^ a2) ^ a3;
          s[4*c+2] = a0 ^ a1 ^ xt(a2) ^ (xt(a3) ^ a3);
          s[4*c+3] = (xt(a0) ^ a0) ^ a1 ^ a2 ^ xt(a3);
        end
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ rk[1407-128*rn-8*i -: 8];
    end
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = s[i];
    return o;
  endfunction
  function automatic logic [15:0] cnt_of(input int u);
    return (u < 3) ? cnt[u] : {12'h0, cnt4};
  endfunction
  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic start_wait(input int u, input logic [127:0] pt, output logic [127:0] ct, output int lat);
    int g;
    g = 0;
    while (!ir[u] && g < 40) begin @(negedge clk); g++; end
    in_block = pt;
    iv[u] = 1'b1;
    @(posedge clk);
    #1 iv[u] = 1'b0;
    chk($sformatf("busy_u%0d", un[u]), {ir[u], ov[u], bz[u]}, 3'b001);
    lat = 0;
    while (!ov[u] && lat < 40) begin @(posedge clk); #1 lat++; end
    ct = ob[u];
  endtask
  task automatic ack(input int u);
    @(negedge clk);
    ordy[u] = 1'b1;
    @(posedge clk);
    #1 ordy[u] = 1'b0;
    cnt_exp[u]++;
    chk($sformatf("count_u%0d", un[u]), cnt_of(u), (u == 3) ? 128'(cnt_exp[u] % 16) : 128'(cnt_exp[u]));
    chk($sformatf("ov_low_u%0d", un[u]), ov[u], 0);
  endtask
  task automatic run_one(input int u, input logic [127:0] pt, output logic [127:0] ct, output int lat);
    start_wait(u, pt, ct, lat);
    ack(u);
  endtask
  initial begin
    logic [127:0] ct, pt, held;
    int           lat, g, t_prev;
    logic         ok;
    vecs[0] = '{128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h3243f6a8885a308d313198a2e0370734,
                128'h3925841d02dc09fbdc118597196a0b32};
    vecs[1] = '{128'h000102030405060708090a0b0c0d0e0f, 128'h00112233445566778899aabbccddeeff,
                128'h69c4e0d86a7b0430d8cdb78070b4c55a};
    vecs[2] = '{128'h0, 128'h0, 128'h66e94bd4ef8a2c3b884cfa59ca342b2e};
    #2;
    for (int u = 0; u < 4; u++) begin
      chk($sformatf("reset_flags_u%0d", un[u]), {ir[u], ov[u], bz[u]}, 3'b100);
      chk($sformatf("reset_out_u%0d", un[u]), ob[u], 0);
      chk($sformatf("reset_cnt_u%0d", un[u]), cnt_of(u), 0);
    end
    @(negedge clk) rst_n = 1'b1;
    for (int v = 0; v < 3; v++) begin
      round_keys = expand(vecs[v].key);
      for (int u = 0; u < 4; u++) begin
        run_one(u, vecs[v].pt, ct, lat);
        chk($sformatf("ct_v%0d_u%0d", v, un[u]), ct, vecs[v].ct);
        chk($sformatf("lat_v%0d_u%0d", v, un[u]), 128'(lat), 128'(10 / un[u]));
      end
    end
    round_keys = expand(vecs[0].key);
    start_wait(0, vecs[0].pt, held, lat);
    ok = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      iv[0] = (i == 5 || i == 6);
      if (ob[0] !== held || ov[0] !== 1'b1 || ir[0] !== 1'b0 || bz[0] !== 1'b0) ok = 1'b0;
    end
    chk("bp_hold", ok, 1);
    chk("bp_data", held, vecs[0].ct);
    iv[0] = 1'b1;
    ack(0);
    chk("bp_no_accept", {ir[0], bz[0]}, 2'b10);
    iv[0] = 1'b0;
    round_keys = expand(vecs[1].key);
    @(negedge clk);
    in_block = vecs[1].pt;
    iv[0] = 1'b1;
    @(posedge clk);
    #1 iv[0] = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_mid_flags", {ir[0], ov[0], bz[0]}, 3'b100);
    chk("rst_mid_out", ob[0], 0);
    chk("rst_mid_cnt", cnt_of(0), 0);
    for (int u = 0; u < 4; u++) cnt_exp[u] = 0;
    @(negedge clk) rst_n = 1'b1;
    run_one(0, vecs[1].pt, ct, lat);
    chk("rst_after_ct", ct, vecs[1].ct);
    chk("rst_after_lat", 128'(lat), 128'(10));
    @(negedge clk) rst_n = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    for (int u = 0; u < 4; u++) cnt_exp[u] = 0;
    round_keys = expand(vecs[0].key);
    iv[0] = 1'b1;
    ordy[0] = 1'b1;
    t_prev = 0;
    for (int n = 0; n < 100; n++) begin
      pt = {$urandom, $urandom, $urandom, $urandom};
      in_block = pt;
      g = 0;
      while (!ir[0] && g < 40) begin @(negedge clk); g++; end
      @(posedge clk);
      #1;
      if (n > 0) chk($sformatf("stream_gap_%0d", n), 128'(cyc - t_prev), 128'(12));
      t_prev = cyc;
      g = 0;
      while (!ov[0] && g < 40) begin @(negedge clk); g++; end
      chk($sformatf("stream_ct_%0d", n), ob[0], model(pt, round_keys));
    end
    iv[0] = 1'b0;
    @(negedge clk);
    ordy[0] = 1'b0;
    chk("stream_count", cnt_of(0), 100);
    for (int n = 0; n < 17; n++) begin
      pt = {$urandom, $urandom, $urandom, $urandom};
      run_one(3, pt, ct, lat);
      chk($sformatf("wrap_ct_%0d", n), ct, model(pt, round_keys));
    end
    chk("wrap_count", cnt4, 1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
